// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - memory-mapped control/status register bank behind the UART command parser
// Reads are answered one cycle later, with read-before-write ordering; the error counter saturates.
module reg_bank #(
   parameter int                                  WORD_WIDTH     = 8,
   parameter int                                  VALUE_WORDS    = 4,
   parameter int                                  NUM_CTRL       = 4,
   parameter int                                  NUM_STATUS     = 4,
   parameter logic [31:0]                         ID_VALUE       = 32'h5245_4731,
   parameter logic [VALUE_WORDS*WORD_WIDTH-1:0]   UNMAPPED_VALUE = '1
) (
   input  logic                                   clk,
   input  logic                                   i_reset_n,
   input  logic                                   i_w_en,
   input  logic [WORD_WIDTH-1:0]                  i_w_addr,
   input  logic [VALUE_WORDS*WORD_WIDTH-1:0]      i_w_data,
   input  logic                                   i_r_en,
   input  logic [WORD_WIDTH-1:0]                  i_r_addr,
   output logic [VALUE_WORDS*WORD_WIDTH-1:0]      o_r_data,
   output logic                                   o_r_valid,
   output logic [NUM_CTRL*VALUE_WORDS*WORD_WIDTH-1:0]   o_ctrl,
   input  logic [NUM_STATUS*VALUE_WORDS*WORD_WIDTH-1:0] i_status,
   output logic [VALUE_WORDS*WORD_WIDTH-1:0]      o_pulse
);

   localparam int DW = VALUE_WORDS * WORD_WIDTH;

   localparam logic [WORD_WIDTH-1:0] A_STATUS = WORD_WIDTH'(8'h40);
   localparam logic [WORD_WIDTH-1:0] A_PULSE  = WORD_WIDTH'(8'h80);
   localparam logic [WORD_WIDTH-1:0] A_ID     = WORD_WIDTH'(8'hF0);
   localparam logic [WORD_WIDTH-1:0] A_WCNT   = WORD_WIDTH'(8'hF1);
   localparam logic [WORD_WIDTH-1:0] A_ECNT   = WORD_WIDTH'(8'hF2);
   localparam logic [DW-1:0]         ID_DW    = DW'(ID_VALUE);

   logic [NUM_CTRL*DW-1:0] ctrl_q, ctrl_d;
   logic [DW-1:0]          pulse_q, pulse_d;
   logic [DW-1:0]          wcnt_q, wcnt_d;
   logic [DW-1:0]          ecnt_q, ecnt_d;
   logic [DW-1:0]          r_data_q, r_data_d;
   logic                   r_valid_q, r_valid_d;
   // Low during the first edge after reset release, so a read issued then is dropped.
   logic                   armed_q;

   logic                   w_ctrl, w_ok, w_err;
   logic                   r_fire, r_hit, r_err;
   logic [DW-1:0]          rd_val;
   logic [DW:0]            ecnt_sum;

   always_comb begin
      rd_val = UNMAPPED_VALUE;
      r_hit  = 1'b0;
      for (int k = 0; k < NUM_CTRL; k++) begin
         if (i_r_addr == WORD_WIDTH'(k)) begin
            rd_val = ctrl_q[k*DW +: DW];
            r_hit  = 1'b1;
         end
      end
      for (int k = 0; k < NUM_STATUS; k++) begin
         if (i_r_addr == A_STATUS + WORD_WIDTH'(k)) begin
            rd_val = i_status[k*DW +: DW];
            r_hit  = 1'b1;
         end
      end
      case (i_r_addr)
         A_PULSE: begin rd_val = '0;     r_hit = 1'b1; end
         A_ID:    begin rd_val = ID_DW;  r_hit = 1'b1; end
         A_WCNT:  begin rd_val = wcnt_q; r_hit = 1'b1; end
         A_ECNT:  begin rd_val = ecnt_q; r_hit = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      ctrl_d = ctrl_q;
      w_ctrl = 1'b0;
      for (int k = 0; k < NUM_CTRL; k++) begin
         if (i_w_addr == WORD_WIDTH'(k)) begin
            w_ctrl = 1'b1;
            if (i_w_en) ctrl_d[k*DW +: DW] = i_w_data;
         end
      end
      w_ok  = w_ctrl || (i_w_addr == A_PULSE) || (i_w_addr == A_ECNT);
      w_err = i_w_en && !w_ok;

      r_fire = i_r_en && armed_q;
      r_err  = r_fire && !r_hit;

      pulse_d = (i_w_en && i_w_addr == A_PULSE) ? i_w_data : '0;
      wcnt_d  = wcnt_q + DW'(i_w_en && w_ok);

      // Up to two error events per cycle; clamp instead of wrapping.
      ecnt_sum = {1'b0, ecnt_q} + (DW+1)'(w_err) + (DW+1)'(r_err);
      if (i_w_en && i_w_addr == A_ECNT) begin
         ecnt_d = DW'(r_err);
      end else if (ecnt_sum[DW]) begin
         ecnt_d = '1;
      end else begin
         ecnt_d = ecnt_sum[DW-1:0];
      end

      r_valid_d = r_fire;
      r_data_d  = r_fire ? rd_val : r_data_q;
   end

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ctrl_q    <= '0;
         pulse_q   <= '0;
         wcnt_q    <= '0;
         ecnt_q    <= '0;
         r_data_q  <= '0;
         r_valid_q <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         pulse_q   <= pulse_d;
         wcnt_q    <= wcnt_d;
         ecnt_q    <= ecnt_d;
         r_data_q  <= r_data_d;
         r_valid_q <= r_valid_d;
         armed_q   <= 1'b1;
      end
   end

   assign o_ctrl    = ctrl_q;
   assign o_pulse   = pulse_q;
   assign o_r_data  = r_data_q;
   assign o_r_valid = r_valid_q;

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - self-checking bench for reg_bank
// Directed vector table, multi-cycle corner sequences and randomized traffic against a reference model.
module tb_reg_bank;

   localparam int NC = 4;

   logic          clk = 1'b0;
   logic          i_reset_n = 1'b0;
   logic          i_w_en = 1'b0;
   logic [7:0]    i_w_addr = '0;
   logic [31:0]   i_w_data = '0;
   logic          i_r_en = 1'b0;
   logic [7:0]    i_r_addr = '0;
   logic [31:0]   o_r_data;
   logic          o_r_valid;
   logic [127:0]  o_ctrl;
   logic [127:0]  i_status = '0;
   logic [31:0]   o_pulse;

   logic          s_w_en = 1'b0;
   logic [7:0]    s_w_addr = '0;
   logic [7:0]    s_w_data = '0;
   logic          s_r_en = 1'b0;
   logic [7:0]    s_r_addr = '0;
   logic [7:0]    s_r_data;
   logic          s_r_valid;
   logic [15:0]   s_ctrl;
   logic [7:0]    s_status = 8'h5A;
   logic [7:0]    s_pulse;

   always #5 clk = ~clk;

   reg_bank dut (
      .clk(clk), .i_reset_n(i_reset_n),
      .i_w_en(i_w_en), .i_w_addr(i_w_addr), .i_w_data(i_w_data),
      .i_r_en(i_r_en), .i_r_addr(i_r_addr),
      .o_r_data(o_r_data), .o_r_valid(o_r_valid),
      .o_ctrl(o_ctrl), .i_status(i_status), .o_pulse(o_pulse)
   );

   // Narrow instance (8-bit words) so the saturating error counter can be driven to its ceiling.
   reg_bank #(.WORD_WIDTH(8), .VALUE_WORDS(1), .NUM_CTRL(2), .NUM_STATUS(1)) dut_s (
      .clk(clk), .i_reset_n(i_reset_n),
      .i_w_en(s_w_en), .i_w_addr(s_w_addr), .i_w_data(s_w_data),
      .i_r_en(s_r_en), .i_r_addr(s_r_addr),
      .o_r_data(s_r_data), .o_r_valid(s_r_valid),
      .o_ctrl(s_ctrl), .i_status(s_status), .o_pulse(s_pulse)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: register file as an array, counters as plain integers.
   logic [31:0] m_ctrl [NC];
   logic [31:0] m_wcnt;
   longint      m_ecnt;
   logic [31:0] m_rdata;
   bit          m_armed;
   logic        exp_valid;
   logic [31:0] exp_rdata, exp_pulse;

   function automatic bit m_mapped(input logic [7:0] a);
      return (int'(a) < NC) || (a inside {[8'h40:8'h43]}) || (a inside {8'h80, 8'hF0, 8'hF1, 8'hF2});
   endfunction

   function automatic bit m_writable(input logic [7:0] a);
      return (int'(a) < NC) || a == 8'h80 || a == 8'hF2;
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a);
      if (int'(a) < NC) return m_ctrl[int'(a)];
      if (a inside {[8'h40:8'h43]}) return i_status[(int'(a) - 64) * 32 +: 32];
      case (a)
         8'h80:   return 32'h0;
         8'hF0:   return 32'h5245_4731;
         8'hF1:   return m_wcnt;
         8'hF2:   return 32'(m_ecnt);
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NC; k++) m_ctrl[k] = '0;
      m_wcnt = '0; m_ecnt = 0; m_rdata = '0; m_armed = 1'b0;
   endtask

   task automatic model_eval();
      bit rerr, werr;
      rerr = 1'b0; werr = 1'b0;
      exp_valid = i_r_en && m_armed;
      if (exp_valid) begin
         m_rdata = m_read(i_r_addr);
         rerr = !m_mapped(i_r_addr);
      end
      exp_rdata = m_rdata;
      exp_pulse = (i_w_en && i_w_addr == 8'h80) ? i_w_data : 32'h0;
      if (i_w_en) begin
         if (m_writable(i_w_addr)) m_wcnt = m_wcnt + 32'd1;
         else werr = 1'b1;
         if (int'(i_w_addr) < NC) m_ctrl[int'(i_w_addr)] = i_w_data;
      end
      if (i_w_en && i_w_addr == 8'hF2) begin
         m_ecnt = longint'(rerr);
      end else begin
         m_ecnt = m_ecnt + longint'(werr) + longint'(rerr);
         if (m_ecnt > 64'hFFFF_FFFF) m_ecnt = 64'hFFFF_FFFF;
      end
      m_armed = 1'b1;
   endtask

   task automatic step();
      if (i_reset_n) model_eval();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        we;
      logic [7:0]  wa;
      logic [31:0] wd;
      logic        re;
      logic [7:0]  ra;
      logic        ev;
      logic [31:0] ed;
      logic [31:0] ep;
      logic [31:0] ec1;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                               input logic re, input logic [7:0] ra, input logic ev,
                               input logic [31:0] ed, input logic [31:0] ep, input logic [31:0] ec1);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
      v.ev = ev; v.ed = ed; v.ep = ep; v.ec1 = ec1;
      return v;
   endfunction

   function automatic logic [7:0] pick_addr();
      case ($urandom_range(0, 9))
         0, 7, 8: return 8'($urandom_range(0, 3));
         1, 9:    return 8'(8'h40 + $urandom_range(0, 3));
         2:       return 8'h80;
         3:       return 8'hF0;
         4:       return 8'hF1;
         5:       return 8'hF2;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   vec_t tbl[$];

   initial begin
      localparam logic [31:0] CB = 32'hCAFE_BABE;
      tbl.push_back(mk(1, 8'h01, CB,        0, 8'h00, 0, 32'h0,        0,      CB));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'h01, 1, CB,           0,      CB));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'hF1, 1, 32'h1,        0,      CB));
      tbl.push_back(mk(0, 8'h00, 0,         0, 8'h00, 0, 32'h1,        0,      CB));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'hF0, 1, 32'h52454731, 0,      CB));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'h43, 1, 32'h12345678, 0,      CB));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'h55, 1, 32'hFFFFFFFF, 0,      CB));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'hF2, 1, 32'h1,        0,      CB));
      tbl.push_back(mk(1, 8'h80, 32'h5,     0, 8'h00, 0, 32'h1,        32'h5,  CB));
      tbl.push_back(mk(1, 8'h80, 32'h5,     0, 8'h00, 0, 32'h1,        32'h5,  CB));
      tbl.push_back(mk(1, 8'h80, 32'hA,     0, 8'h00, 0, 32'h1,        32'hA,  CB));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'h80, 1, 32'h0,        0,      CB));
      tbl.push_back(mk(1, 8'h00, 32'h11,    0, 8'h00, 0, 32'h0,        0,      CB));
      tbl.push_back(mk(1, 8'h00, 32'hAA,    1, 8'h00, 1, 32'h11,       0,      CB));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'h00, 1, 32'hAA,       0,      CB));
      tbl.push_back(mk(1, 8'h01, 32'h5,     1, 8'hF1, 1, 32'h6,        0,      32'h5));
      tbl.push_back(mk(1, 8'hF0, 32'hDEAD,  1, 8'h99, 1, 32'hFFFFFFFF, 0,      32'h5));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'hF2, 1, 32'h3,        0,      32'h5));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'hF0, 1, 32'h52454731, 0,      32'h5));
      tbl.push_back(mk(1, 8'hF2, 32'h0,     1, 8'h99, 1, 32'hFFFFFFFF, 0,      32'h5));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'hF2, 1, 32'h1,        0,      32'h5));
      tbl.push_back(mk(1, 8'hF1, 32'h77,    1, 8'hF1, 1, 32'h8,        0,      32'h5));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'hF1, 1, 32'h8,        0,      32'h5));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'hF2, 1, 32'h2,        0,      32'h5));
      tbl.push_back(mk(1, 8'h43, 32'h1,     1, 8'h43, 1, 32'h12345678, 0,      32'h5));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'hF2, 1, 32'h3,        0,      32'h5));
      tbl.push_back(mk(1, 8'h04, 32'h1,     1, 8'h04, 1, 32'hFFFFFFFF, 0,      32'h5));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'hF2, 1, 32'h5,        0,      32'h5));
      tbl.push_back(mk(1, 8'hF2, 32'h9,     1, 8'hF2, 1, 32'h5,        0,      32'h5));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'hF2, 1, 32'h0,        0,      32'h5));
      tbl.push_back(mk(0, 8'h00, 0,         1, 8'hF1, 1, 32'h9,        0,      32'h5));

      model_reset();
      i_status = {32'h12345678, 32'h0BADF00D, 32'h55AA55AA, 32'hA0A0A0A0};

      repeat (3) @(posedge clk);
      #1;
      chk("reset r_valid", 128'(o_r_valid), 128'h0);
      chk("reset r_data", 128'(o_r_data), 128'h0);
      chk("reset ctrl", o_ctrl, 128'h0);
      chk("reset pulse", 128'(o_pulse), 128'h0);

      // A read presented on the edge that follows reset release must be dropped.
      i_reset_n = 1'b1;
      i_r_en = 1'b1; i_r_addr = 8'hF0;
      step();
      chk("release read valid", 128'(o_r_valid), 128'h0);
      i_r_en = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         i_w_en = tbl[i].we; i_w_addr = tbl[i].wa; i_w_data = tbl[i].wd;
         i_r_en = tbl[i].re; i_r_addr = tbl[i].ra;
         step();
         chk($sformatf("row%0d r_valid", i), 128'(o_r_valid), 128'(tbl[i].ev));
         chk($sformatf("row%0d r_data", i), 128'(o_r_data), 128'(tbl[i].ed));
         chk($sformatf("row%0d pulse", i), 128'(o_pulse), 128'(tbl[i].ep));
         chk($sformatf("row%0d ctrl1", i), 128'(o_ctrl[63:32]), 128'(tbl[i].ec1));
      end
      i_w_en = 1'b0; i_r_en = 1'b0;
      step();
      chk("valid drops", 128'(o_r_valid), 128'h0);

      for (int i = 0; i < 400; i++) begin
         i_status = {$urandom, $urandom, $urandom, $urandom};
         i_w_en = 1'($urandom_range(0, 1));
         i_w_addr = pick_addr();
         i_w_data = $urandom;
         i_r_en = ($urandom_range(0, 2) != 0);
         i_r_addr = (i_w_en && $urandom_range(0, 4) == 0) ? i_w_addr : pick_addr();
         step();
         chk($sformatf("rnd%0d r_valid", i), 128'(o_r_valid), 128'(exp_valid));
         chk($sformatf("rnd%0d r_data", i), 128'(o_r_data), 128'(exp_rdata));
         chk($sformatf("rnd%0d pulse", i), 128'(o_pulse), 128'(exp_pulse));
         chk($sformatf("rnd%0d ctrl", i), o_ctrl,
             {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]});
      end
      i_w_en = 1'b0; i_r_en = 1'b0;
      step();

      // Saturation on the narrow instance: two errors per cycle.
      s_w_en = 1'b1; s_w_addr = 8'hF0; s_r_en = 1'b1; s_r_addr = 8'h99;
      repeat (127) step();
      s_w_en = 1'b0; s_r_addr = 8'hF2;
      step();
      chk("sat pre valid", 128'(s_r_valid), 128'h1);
      chk("sat pre count", 128'(s_r_data), 128'hFE);
      s_w_en = 1'b1; s_r_addr = 8'h99;
      step();
      s_w_en = 1'b0; s_r_addr = 8'hF2;
      step();
      chk("sat reached", 128'(s_r_data), 128'hFF);
      s_w_en = 1'b1; s_r_addr = 8'h99;
      step();
      s_w_en = 1'b0; s_r_addr = 8'hF2;
      step();
      chk("sat held", 128'(s_r_data), 128'hFF);
      s_r_addr = 8'hF0;
      step();
      chk("narrow id", 128'(s_r_data), 128'h31);
      s_r_en = 1'b0;

      // Reset asserted before an outstanding read and pulse write reach their edge.
      i_r_en = 1'b1; i_r_addr = 8'h01;
      i_w_en = 1'b1; i_w_addr = 8'h80; i_w_data = 32'h77;
      @(negedge clk);
      i_reset_n = 1'b0;
      #1;
      chk("async ctrl", o_ctrl, 128'h0);
      i_w_addr = 8'h00; i_w_data = 32'hFFFF_FFFF;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("hold%0d r_valid", c), 128'(o_r_valid), 128'h0);
         chk($sformatf("hold%0d r_data", c), 128'(o_r_data), 128'h0);
         chk($sformatf("hold%0d ctrl", c), o_ctrl, 128'h0);
         chk($sformatf("hold%0d pulse", c), 128'(o_pulse), 128'h0);
      end
      i_w_en = 1'b0; i_r_en = 1'b0;
      i_reset_n = 1'b1;
      model_reset();
      step();
      chk("post ctrl", o_ctrl, 128'h0);
      i_r_en = 1'b1; i_r_addr = 8'hF1;
      step();
      chk("post wcnt", 128'(o_r_data), 128'h0);
      i_r_addr = 8'hF2;
      step();
      chk("post ecnt", 128'(o_r_data), 128'h0);
      chk("post valid", 128'(o_r_valid), 128'h1);
      i_r_en = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Memory-mapped register bank that sits directly downstream of the UART command parser.
- Consumes its write strobe/address/data and read strobe/address.
- Returns read data plus a one-cycle valid, which feeds the parser's read-back serializer.
- Exposes control registers, samples status inputs, generates one-cycle pulse strobes, and keeps access/error counters.

Parameters:
- WORD_WIDTH, 8, address width and serial word width.
- VALUE_WORDS, 4, words per register; DW = VALUE_WORDS*WORD_WIDTH (32 by default).
- NUM_CTRL, 4, number of RW control registers at addresses 0x00..NUM_CTRL-1; legal range 1..64.
- NUM_STATUS, 4, number of RO status registers at 0x40..0x40+NUM_STATUS-1; legal range 1..64.
- ID_VALUE, 32'h5245_4731, constant returned at 0xF0; truncated or zero-extended to DW.
- UNMAPPED_VALUE, all-ones, DW-bit value returned by reads of unmapped addresses.

Ports:
- clk  input  1  clock.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_w_en  input  1  write strobe, one cycle per write.
- i_w_addr  input  WORD_WIDTH  write address.
- i_w_data  input  DW  write data.
- i_r_en  input  1  read strobe, one cycle per read.
- i_r_addr  input  WORD_WIDTH  read address.
- o_r_data  output  DW  read data.
- o_r_valid  output  1  read data valid, one-cycle pulse.
- o_ctrl  output  NUM_CTRL*DW  control registers concatenated; register k occupies bits [k*DW +: DW].
- i_status  input  NUM_STATUS*DW  status inputs, same packing as o_ctrl.
- o_pulse  output  DW  one-cycle strobes.

Behaviour:
- Reset: async assert, sync-style deassert handled upstream. All of o_ctrl, o_r_data, o_r_valid, o_pulse, write counter and error counter go to 0. A read issued in the reset-release cycle or earlier produces no valid.
- Address map:
  - 0x00..NUM_CTRL-1: RW control.
  - 0x40..: RO status.
  - 0x80: pulse (write-only, reads return 0).
  - 0xF0: ID (RO).
  - 0xF1: write counter (RO).
  - 0xF2: error counter (read returns count; any write clears it).
  - All other addresses are unmapped.
- Write:
  - Sampled on the rising edge where i_w_en=1.
  - Control register k updates at that edge and is visible on o_ctrl in the next cycle.
  - Write to 0x80 drives o_pulse=i_w_data for exactly one cycle (the cycle after the write), then o_pulse returns to 0. Back-to-back pulse writes give consecutive pulse cycles with the new data.
  - Write counter (DW bits, wraps) increments on every write to a writable address: control, 0x80, 0xF2.
  - Writes to RO (status, 0xF0, 0xF1) or unmapped addresses change no register and count as errors.
- Read:
  - i_r_en=1 at cycle N gives o_r_valid=1 at N+1 only, with o_r_data set to the addressed value as of cycle N.
  - Status reads return i_status sampled at edge N.
  - o_r_data holds its value until the next read; it is not cleared when o_r_valid drops.
  - Reads every cycle are supported, giving a valid every cycle.
  - A read of an unmapped address returns UNMAPPED_VALUE and counts as an error.
- Simultaneous read and write, same address, same cycle: the read returns the pre-write value (read-before-write). This includes 0xF1, where the read returns the count before the increment.
- Error counter:
  - Increments by the number of error events in the cycle (0, 1 or 2) and saturates at all-ones; it never wraps.
  - A write to 0xF2 in a cycle that also has a read error loads 1, not 0.
- All address decode uses the full WORD_WIDTH address; there is no aliasing.

Test Plan:
- Reset, then write 0x01=0xCAFEBABE, then read 0x01 -> o_ctrl[63:32]=0xCAFEBABE one cycle after the write; o_r_valid pulses exactly one cycle after i_r_en with o_r_data=0xCAFEBABE; write counter reads 1.
- Read 0xF0, 0x43 (i_status[127:96]=0x12345678) and 0x55 on consecutive cycles -> three consecutive valids with 0x52454731, 0x12345678, 0xFFFFFFFF; 0xF2 then reads 1.
- Write 0x80=0x00000005 on two consecutive cycles, then 0x0000000A -> o_pulse=5,5,0xA on three consecutive cycles, then 0; 0x80 reads 0.
- Same cycle: write 0x00=0xAA and read 0x00 (old value 0x11) -> read returns 0x11; the next read returns 0xAA.
- Same cycle: write to 0xF0 and read 0x99 -> error counter +2, ID unchanged; next, write 0xF2 together with a read of 0x99 -> error counter reads 1; force the counter to all-ones plus one error -> stays all-ones.
- Assert i_reset_n=0 in the cycle after i_r_en -> no o_r_valid; all outputs 0 while reset is held; o_ctrl=0 after release.
